// File: rtl/execute_md.sv
// EX stage: single-cycle RV32I/RV64I ALU with a multi-cycle multiply/divide unit.
// Forwarding selects (fwd_a/fwd_b) encode 0 = NONE, 1 = EX_EX, 2 = MEM_EX.
module execute_md #(
    parameter int XLEN    = 32,
    parameter int M_EXT   = 1,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid_in,
    input  logic            flush,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] ex_ex_fwd_data,
    input  logic [XLEN-1:0] mem_ex_fwd_data,
    output logic            ex_stall,
    output logic            result_valid,
    output logic [XLEN-1:0] alu_result,
    output logic            rd_wren,
    output logic [XLEN-1:0] rs2_fwd,
    output logic [1:0]      fsm_state
);
    localparam int CW = $clog2(XLEN + 1);
    localparam int SW = $clog2(XLEN);
    localparam logic [1:0] ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DONE = 2'd3;
    localparam logic [1:0] FWD_EX_EX = 2'd1, FWD_MEM_EX = 2'd2;
    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                           OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011,
                           OPC_OPIMM32 = 7'b0011011, OPC_OP32 = 7'b0111011;
    localparam logic [CW-1:0] MUL_LAST = CW'((MUL_LAT >= 2) ? MUL_LAT - 2 : 0);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

    logic [1:0]      state, state_n;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] a_q, b_q, rem_q, res_q;
    logic [2:0]      f3_q;
    logic            neg_q, neg_r, launch;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    logic [XLEN-1:0] fwd_a_val, op_a, op_b;
    logic uses_pc, uses_imm, is_w, writes, is_mop, mop_en;

    always_comb begin
        case (fwd_a)
            FWD_EX_EX:  fwd_a_val = ex_ex_fwd_data;
            FWD_MEM_EX: fwd_a_val = mem_ex_fwd_data;
            default:    fwd_a_val = rs1;
        endcase
        case (fwd_b)
            FWD_EX_EX:  rs2_fwd = ex_ex_fwd_data;
            FWD_MEM_EX: rs2_fwd = mem_ex_fwd_data;
            default:    rs2_fwd = rs2;
        endcase
    end

    assign uses_pc  = (opcode == OPC_AUIPC) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign uses_imm = (opcode == OPC_OPIMM) || (opcode == OPC_LOAD) || (opcode == OPC_JALR) ||
                      (opcode == OPC_STORE) || (opcode == OPC_LUI) || (opcode == OPC_AUIPC) ||
                      (opcode == OPC_OPIMM32);
    assign is_w     = (XLEN == 64) && ((opcode == OPC_OP32) || (opcode == OPC_OPIMM32));
    assign writes   = (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                      (opcode == OPC_JALR) || (opcode == OPC_LOAD) || (opcode == OPC_OP) ||
                      (opcode == OPC_OPIMM) || is_w;
    assign is_mop   = (opcode == OPC_OP) && (f7 == 7'b0000001);
    assign mop_en   = is_mop && (M_EXT != 0);
    assign op_a     = uses_pc ? pc : fwd_a_val;
    assign op_b     = uses_imm ? imm : rs2_fwd;

    logic [XLEN-1:0]        base, alu_out;
    logic signed [XLEN-1:0] sra_v;
    logic [31:0]            w_val;
    logic signed [31:0]     w_sra;
    logic                   sub;

    always_comb begin
        // Only register-register ops subtract; for OP-IMM bit 30 is an immediate bit.
        sub   = ((opcode == OPC_OP) || (opcode == OPC_OP32)) && instr[30];
        sra_v = $signed(op_a) >>> op_b[SW-1:0];
        w_sra = $signed(op_a[31:0]) >>> op_b[4:0];
        case (f3)
            3'b000:  base = sub ? op_a - op_b : op_a + op_b;
            3'b001:  base = op_a << op_b[SW-1:0];
            3'b010:  base = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            3'b011:  base = {{(XLEN-1){1'b0}}, op_a < op_b};
            3'b100:  base = op_a ^ op_b;
            3'b101:  base = instr[30] ? sra_v : op_a >> op_b[SW-1:0];
            3'b110:  base = op_a | op_b;
            default: base = op_a & op_b;
        endcase
        case (f3)
            3'b000:  w_val = sub ? op_a[31:0] - op_b[31:0] : op_a[31:0] + op_b[31:0];
            3'b001:  w_val = op_a[31:0] << op_b[4:0];
            3'b101:  w_val = instr[30] ? w_sra : op_a[31:0] >> op_b[4:0];
            default: w_val = op_a[31:0] + op_b[31:0];
        endcase
        if (opcode == OPC_LUI)                             alu_out = op_b;
        else if (opcode == OPC_JAL || opcode == OPC_JALR)  alu_out = op_a + XLEN'(4);
        else if (opcode == OPC_OP || opcode == OPC_OPIMM)  alu_out = base;
        else if (is_w)                                     alu_out = XLEN'($signed(w_val));
        else                                               alu_out = op_a + op_b;
    end

    // Multiplier reads live operands only when MUL_LAT=1 launches straight into DONE.
    logic [XLEN-1:0]   m_a, m_b, mul_res;
    logic [2:0]        m_f3;
    logic [2*XLEN-1:0] m_ea, m_eb, prod;

    always_comb begin
        m_a  = (state == ST_IDLE) ? op_a : a_q;
        m_b  = (state == ST_IDLE) ? op_b : b_q;
        m_f3 = (state == ST_IDLE) ? f3 : f3_q;
        m_ea = (m_f3 == 3'b001 || m_f3 == 3'b010) ? {{XLEN{m_a[XLEN-1]}}, m_a} : {{XLEN{1'b0}}, m_a};
        m_eb = (m_f3 == 3'b001) ? {{XLEN{m_b[XLEN-1]}}, m_b} : {{XLEN{1'b0}}, m_b};
        prod = m_ea * m_eb;
        mul_res = (m_f3 == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    logic            div_signed, a_neg, b_neg, div_zero, div_ovf, ge;
    logic [XLEN-1:0] a_abs, b_abs, special_res, rem_diff, rem_n, q_n, div_res;
    logic [XLEN:0]   rem_sh;

    always_comb begin
        div_signed  = !f3[0];
        a_neg       = div_signed && op_a[XLEN-1];
        b_neg       = div_signed && op_b[XLEN-1];
        a_abs       = a_neg ? -op_a : op_a;
        b_abs       = b_neg ? -op_b : op_b;
        div_zero    = (op_b == '0);
        div_ovf     = div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special_res = div_zero ? (f3[1] ? op_a : '1) : (f3[1] ? '0 : op_a);
        // Restoring step: a_q shifts the dividend out and the quotient in.
        rem_sh   = {rem_q, a_q[XLEN-1]};
        ge       = rem_sh >= {1'b0, b_q};
        rem_diff = rem_sh[XLEN-1:0] - b_q;
        rem_n    = ge ? rem_diff : rem_sh[XLEN-1:0];
        q_n      = {a_q[XLEN-2:0], ge};
        div_res  = f3_q[1] ? (neg_r ? -rem_n : rem_n) : (neg_q ? -q_n : q_n);
    end

    // ex_stall holds the instruction in EX; result_valid marks the single cycle in which
    // alu_result/rd_wren are meaningful. The two are never high together.
    always_comb begin
        state_n      = state;
        launch       = 1'b0;
        ex_stall     = 1'b0;
        result_valid = 1'b0;
        rd_wren      = 1'b0;
        alu_result   = '0;
        case (state)
            ST_IDLE: begin
                if (ex_valid_in) begin
                    if (mop_en) begin
                        launch   = 1'b1;
                        ex_stall = 1'b1;
                        if (f3[2]) state_n = (div_zero || div_ovf) ? ST_DONE : ST_DIV;
                        else       state_n = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
                    end else begin
                        result_valid = 1'b1;
                        rd_wren      = writes && !is_mop;
                        alu_result   = is_mop ? '0 : alu_out;
                    end
                end
            end
            ST_MUL: begin
                ex_stall = 1'b1;
                if (cnt == MUL_LAST) state_n = ST_DONE;
            end
            ST_DIV: begin
                ex_stall = 1'b1;
                if (cnt == DIV_LAST) state_n = ST_DONE;
            end
            default: begin
                result_valid = 1'b1;
                rd_wren      = 1'b1;
                alu_result   = res_q;
                state_n      = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_n      = ST_IDLE;
            launch       = 1'b0;
            ex_stall     = 1'b0;
            result_valid = 1'b0;
            rd_wren      = 1'b0;
            alu_result   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rem_q <= '0;
            res_q <= '0;
            f3_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: if (launch) begin
                    f3_q <= f3;
                    cnt  <= '0;
                    if (f3[2]) begin
                        if (div_zero || div_ovf) begin
                            res_q <= special_res;
                        end else begin
                            a_q   <= a_abs;
                            b_q   <= b_abs;
                            rem_q <= '0;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end
                    end else begin
                        a_q <= op_a;
                        b_q <= op_b;
                        if (MUL_LAT == 1) res_q <= mul_res;
                    end
                end
                ST_MUL: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == MUL_LAST) res_q <= mul_res;
                end
                ST_DIV: begin
                    cnt   <= cnt + CW'(1);
                    a_q   <= q_n;
                    rem_q <= rem_n;
                    if (cnt == DIV_LAST) res_q <= div_res;
                end
                default: ;
            endcase
        end
    end

    assign fsm_state = state;
endmodule

// File: tb/tb_execute_md.sv
// Randomized scoreboard bench for execute_md (XLEN=32, M_EXT=1, MUL_LAT=2).
module tb_execute_md;
    localparam logic [1:0] F_NONE = 2'd0, F_EXEX = 2'd1, F_MEMEX = 2'd2;
    localparam int ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4, XOR_ = 5, SRL = 6, SRA = 7,
                   OR_ = 8, AND_ = 9, ADDI = 10, SLTIU = 11, XORI = 12, SRAI = 13, LUI = 14,
                   AUIPC = 15, JAL = 16, SW = 17, MUL = 18, MULH = 19, MULHSU = 20, MULHU = 21,
                   DIV = 22, DIVU = 23, REM = 24, REMU = 25;

    logic clk = 1'b0;
    logic rst, ex_valid_in, flush;
    logic [31:0] instr, pc, rs1, rs2, imm, ex_ex_fwd_data, mem_ex_fwd_data;
    logic [1:0]  fwd_a, fwd_b;
    logic        ex_stall, result_valid, rd_wren;
    logic [31:0] alu_result, rs2_fwd;
    logic [1:0]  fsm_state;

    execute_md #(.XLEN(32), .M_EXT(1), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .ex_valid_in(ex_valid_in), .flush(flush), .instr(instr),
        .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_ex_fwd_data(ex_ex_fwd_data), .mem_ex_fwd_data(mem_ex_fwd_data),
        .ex_stall(ex_stall), .result_valid(result_valid), .alu_result(alu_result),
        .rd_wren(rd_wren), .rs2_fwd(rs2_fwd), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic        exp_w_q[$];
    logic        exp_c_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r,
                                         input logic [31:0] e, input logic [31:0] m);
        case (s)
            F_EXEX:  return e;
            F_MEMEX: return m;
            default: return r;
        endcase
    endfunction

    function automatic logic [31:0] enc(input int op);
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [31:0] w;
        opc = 7'b0110011; f7 = 7'h00; f3 = 3'd0;
        case (op)
            SUB:    f7 = 7'h20;
            SLL:    f3 = 3'd1;
            SLT:    f3 = 3'd2;
            SLTU:   f3 = 3'd3;
            XOR_:   f3 = 3'd4;
            SRL:    f3 = 3'd5;
            SRA:    begin f3 = 3'd5; f7 = 7'h20; end
            OR_:    f3 = 3'd6;
            AND_:   f3 = 3'd7;
            ADDI:   begin opc = 7'b0010011; f7 = 7'($urandom); end
            SLTIU:  begin opc = 7'b0010011; f3 = 3'd3; f7 = 7'($urandom); end
            XORI:   begin opc = 7'b0010011; f3 = 3'd4; f7 = 7'($urandom); end
            SRAI:   begin opc = 7'b0010011; f3 = 3'd5; f7 = 7'h20; end
            LUI:    begin opc = 7'b0110111; f7 = 7'($urandom); end
            AUIPC:  begin opc = 7'b0010111; f7 = 7'($urandom); end
            JAL:    begin opc = 7'b1101111; f7 = 7'($urandom); end
            SW:     begin opc = 7'b0100011; f3 = 3'd2; end
            default: if (op >= MUL) begin f7 = 7'h01; f3 = 3'(op - MUL); end
        endcase
        w = {f7, 5'd3, 5'd2, f3, 5'd1, opc};
        return w;
    endfunction

    task automatic model(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p,
                         output logic [31:0] v, output logic w, output int lat);
        logic signed [31:0] sa, sb;
        logic [63:0] pu;
        longint ps;
        sa = a; sb = b; v = 32'd0; w = 1'b1; lat = 0;
        pu = {32'd0, a} * {32'd0, b};
        case (op)
            ADD:    v = a + b;
            SUB:    v = a - b;
            SLL:    v = a << b[4:0];
            SLT:    v = (sa < sb) ? 32'd1 : 32'd0;
            SLTU:   v = (a < b) ? 32'd1 : 32'd0;
            XOR_:   v = a ^ b;
            SRL:    v = a >> b[4:0];
            SRA:    v = sa >>> b[4:0];
            OR_:    v = a | b;
            AND_:   v = a & b;
            ADDI:   v = a + im;
            SLTIU:  v = (a < im) ? 32'd1 : 32'd0;
            XORI:   v = a ^ im;
            SRAI:   v = sa >>> im[4:0];
            LUI:    v = im;
            AUIPC:  v = p + im;
            JAL:    v = p + 32'd4;
            SW:     w = 1'b0;
            MUL:    begin v = pu[31:0]; lat = 2; end
            MULH:   begin ps = longint'(sa) * longint'(sb); v = ps[63:32]; lat = 2; end
            MULHSU: begin ps = longint'(sa) * longint'({32'd0, b}); v = ps[63:32]; lat = 2; end
            MULHU:  begin v = pu[63:32]; lat = 2; end
            default: begin
                if (b == 32'd0) begin
                    v = (op == DIV || op == DIVU) ? 32'hFFFF_FFFF : a;
                    lat = 1;
                end else if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    v = (op == DIV) ? a : 32'd0;
                    lat = 1;
                end else begin
                    case (op)
                        DIV:     v = sa / sb;
                        DIVU:    v = a / b;
                        REM:     v = sa % sb;
                        default: v = a % b;
                    endcase
                    lat = 33;
                end
            end
        endcase
    endtask

    task automatic issue(input int op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [31:0] p,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] exd, input logic [31:0] memd,
                         input bit force_exp, input logic [31:0] fval, input int flat);
        logic [31:0] a, b, v;
        logic w;
        int lat, n;
        a = pick(fa, r1, exd, memd);
        b = pick(fb, r2, exd, memd);
        model(op, a, b, im, p, v, w, lat);
        if (force_exp) begin v = fval; lat = flat; end
        exp_q.push_back(v);
        exp_w_q.push_back(w);
        exp_c_q.push_back(w);
        @(posedge clk); #1;
        instr = enc(op); rs1 = r1; rs2 = r2; imm = im; pc = p; fwd_a = fa; fwd_b = fb;
        ex_ex_fwd_data = exd; mem_ex_fwd_data = memd; ex_valid_in = 1'b1; flush = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (n == 0) check("rs2_fwd", rs2_fwd, b);
            if (!ex_stall) break;
            n++;
            if (n > 100) begin
                checks++; failures++;
                $display("FAIL stall_timeout: got more than 100 stall cycles expected %0d", lat);
                break;
            end
            if (n >= 2) begin
                rs1 = $urandom; rs2 = $urandom; imm = $urandom; pc = $urandom;
                ex_ex_fwd_data = $urandom; mem_ex_fwd_data = $urandom;
                fwd_a = 2'($urandom_range(0, 2)); fwd_b = 2'($urandom_range(0, 2));
            end
        end
        check("stall_cycles", n, lat);
        @(posedge clk); #1;
        ex_valid_in = 1'b0;
    endtask

    always @(negedge clk) begin
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_result: got result_valid=1 alu_result=%h expected no result", alu_result);
            end else begin
                logic [31:0] v;
                logic w, c;
                v = exp_q.pop_front(); w = exp_w_q.pop_front(); c = exp_c_q.pop_front();
                check("rd_wren", 32'(rd_wren), 32'(w));
                if (c) check("alu_result", alu_result, v);
            end
        end
    end

    task automatic check_quiet(input string nm);
        check({nm, "_ex_stall"}, 32'(ex_stall), 32'd0);
        check({nm, "_result_valid"}, 32'(result_valid), 32'd0);
        check({nm, "_rd_wren"}, 32'(rd_wren), 32'd0);
        check({nm, "_alu_result"}, alu_result, 32'd0);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before 900000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ex_valid_in = 1'b0; flush = 1'b0; instr = 32'd0; pc = 32'd0; rs1 = 32'd0;
        rs2 = 32'd0; imm = 32'd0; fwd_a = F_NONE; fwd_b = F_NONE;
        ex_ex_fwd_data = 32'd0; mem_ex_fwd_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("in_reset");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");

        issue(ADD, 32'd5, 32'd0, 32'd0, 32'd0, F_NONE, F_EXEX, 32'd10, 32'd0, 1, 32'd15, 0);
        issue(MUL, 32'd7, -32'sd3, 32'd0, 32'd0, F_NONE, F_NONE, 32'd0, 32'd0, 1, 32'hFFFF_FFEB, 2);
        issue(MULHU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, F_NONE, F_NONE, 32'd0, 32'd0, 1, 32'd1, 2);
        issue(DIV, -32'sd7, 32'd2, 32'd0, 32'd0, F_NONE, F_NONE, 32'd0, 32'd0, 1, 32'hFFFF_FFFD, 33);
        issue(REM, -32'sd7, 32'd2, 32'd0, 32'd0, F_NONE, F_NONE, 32'd0, 32'd0, 1, 32'hFFFF_FFFF, 33);
        issue(DIVU, 32'd100, 32'd7, 32'd0, 32'd0, F_NONE, F_NONE, 32'd0, 32'd0, 1, 32'd14, 33);
        issue(DIV, 32'd5, 32'd0, 32'd0, 32'd0, F_NONE, F_NONE, 32'd0, 32'd0, 1, 32'hFFFF_FFFF, 1);
        issue(REM, 32'd5, 32'd0, 32'd0, 32'd0, F_NONE, F_NONE, 32'd0, 32'd0, 1, 32'd5, 1);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, F_NONE, F_NONE, 32'd0, 32'd0, 1, 32'h8000_0000, 1);
        issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, F_NONE, F_NONE, 32'd0, 32'd0, 1, 32'd0, 1);
        issue(ADDI, 32'd20, 32'd0, 32'd3, 32'd0, F_MEMEX, F_NONE, 32'd0, 32'd100, 1, 32'd103, 0);

        // DIV killed by flush on its tenth iteration; no result must ever appear.
        @(posedge clk); #1;
        instr = enc(DIV); rs1 = -32'sd7; rs2 = 32'd2; fwd_a = F_NONE; fwd_b = F_NONE;
        ex_valid_in = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("div_busy_stall", 32'(ex_stall), 32'd1);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("flush_ex_stall", 32'(ex_stall), 32'd0);
        check("flush_result_valid", 32'(result_valid), 32'd0);
        @(posedge clk); #1 flush = 1'b0; ex_valid_in = 1'b0;
        @(negedge clk);
        check("flush_idle_state", 32'(fsm_state), 32'd0);
        check_quiet("after_flush");
        repeat (40) @(posedge clk);
        issue(ADD, 32'd3, 32'd4, 32'd0, 32'd0, F_NONE, F_NONE, 32'd0, 32'd0, 0, 32'd0, 0);

        // Reset in the last MUL cycle aborts the op silently.
        @(posedge clk); #1;
        instr = enc(MUL); rs1 = 32'd9; rs2 = 32'd9; ex_valid_in = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; ex_valid_in = 1'b0; instr = 32'd0; rs1 = 32'd0; rs2 = 32'd0;
        @(posedge clk);
        @(negedge clk);
        check_quiet("reset_mid_mul");
        check("reset_mid_mul_rs2_fwd", rs2_fwd, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_quiet("after_mul_abort");

        for (int i = 0; i < 200; i++) begin
            issue($urandom_range(0, 25), rand_val(), rand_val(), rand_val(), $urandom,
                  2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), rand_val(), rand_val(),
                  0, 32'd0, 0);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute_md.md
EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values are 32 and 64.
REQ-002 Parameter M_EXT, default 1: 1 enables the multiply/divide unit; 0 treats M-ops as non-writing.
REQ-003 Parameter MUL_LAT, default 2: multiply latency in cycles; legal range 1..4.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset; synchronous and active-high.
REQ-006 Port ex_valid_in, input, 1 bit: the EX stage holds a valid instruction.
REQ-007 Port flush, input, 1 bit: kill the EX instruction, including any in-flight M-op.
REQ-008 Port instr, input, 32 bits: the instruction word.
REQ-009 Ports pc, rs1, rs2 and imm, input, XLEN bits each: operands.
REQ-010 Ports fwd_a and fwd_b, input, fwd_sel_t: forwarding select per operand; encoding NONE, EX_EX, MEM_EX.
REQ-011 Ports ex_ex_fwd_data and mem_ex_fwd_data, input, XLEN bits each: forwarded values.
REQ-012 Port ex_stall, output, 1 bit: hold IF/ID/EX this cycle.
REQ-013 Port result_valid, output, 1 bit: alu_result and rd_wren are valid this cycle.
REQ-014 Port alu_result, output, XLEN bits: the result.
REQ-015 Port rd_wren, output, 1 bit: write rd; qualified by result_valid.
REQ-016 Port rs2_fwd, output, XLEN bits: rs2 after fwd_b selection, for stores.

Function
REQ-017 Operand A: fwd_a selects rs1 / ex_ex_fwd_data / mem_ex_fwd_data; pc replaces it for AUIPC, JAL and JALR.
REQ-018 Operand B: fwd_b selects the same way; imm replaces it for I/S/U-type; rs2_fwd is always the fwd_b-selected rs2.
REQ-019 Non-M-op, state IDLE, ex_valid_in=1: result combinational in the same cycle; result_valid=1, ex_stall=0; RV32I/RV64I ALU semantics; rd_wren=1 for rd-writing types.
REQ-020 M-op is opcode 0110011 with funct7 0000001; when M_EXT=0 it gives result_valid=1, rd_wren=0, alu_result=0.
REQ-021 FSM states: IDLE, MUL, DIV, DONE.
REQ-022 IDLE, valid M-op, no flush: capture A, B and funct3 into registers; go MUL or DIV; ex_stall=1 and result_valid=0 in that same cycle T.
REQ-023 MUL: MUL/MULH/MULHSU/MULHU with full 2*XLEN product; low or high half per funct3; DONE reached at T+MUL_LAT; ex_stall=1 in cycles T..T+MUL_LAT-1.
REQ-024 DIV: restoring radix-2 algorithm; one quotient bit per cycle; XLEN iterations; DONE at T+XLEN+1; signs fixed up in the final cycle; REM sign follows the dividend.
REQ-025 Divisor 0: quotient all-ones; remainder = dividend; DONE at T+1.
REQ-026 Signed overflow (most-negative / -1): quotient = dividend; remainder 0; DONE at T+1.
REQ-027 DONE: result_valid=1, rd_wren=1, ex_stall=0, alu_result from the result register; next state IDLE; must not relaunch even though ex_valid_in is still high.
REQ-028 Internal counter is ceil(log2(XLEN+1)) bits; wraps never, because it is cleared on entry to DIV.
REQ-029 flush in any state: next state IDLE; result_valid=0 and ex_stall=0 that cycle; flush has priority over launch and completion.
REQ-030 ex_valid_in=0 in IDLE: result_valid=0, ex_stall=0.
REQ-031 Captured operands are immune to forwarding-input changes during MUL/DIV.

Reset
REQ-032 rst=1 at a clock edge: state IDLE; counter, operand and result registers cleared to 0.
REQ-033 During reset and on the first cycle after it, outputs are: ex_stall=0, result_valid=0, rd_wren=0, alu_result=0 (when ex_valid_in=0).
REQ-034 Reset mid-operation aborts the M-op with no result_valid pulse.

Verification
REQ-035 ADD; rs1=5; fwd_b=EX_EX; ex_ex_fwd_data=10 -> same cycle alu_result=15, result_valid=1, ex_stall=0.
REQ-036 MUL 7 x -3, MUL_LAT=2 -> ex_stall high 2 cycles, then alu_result=0xFFFFFFEB with result_valid=1; MULHU 0xFFFFFFFF x 2 -> 1.
REQ-037 DIV -7/2 -> 33 stall cycles, then -3; REM -7/2 -> -1; DIVU 100/7 -> 14.
REQ-038 DIV 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
REQ-039 flush at iteration 10 of a DIV -> IDLE next cycle, no result_valid pulse; a following ADD completes normally.
REQ-040 rst asserted mid-MUL -> all outputs 0 the next cycle; ex_stall low.
